// File: rtl/spi_input_controller.sv
// SPI slave receive front-end. Brings SCK/SS/MOSI into the clk domain,
// produces the shared shift_SPI strobe, assembles MSB-first bytes and
// decodes host commands (cost request, image load into the pixel buffer).
module spi_input_controller #(
  parameter int unsigned NUM_PIXELS = 784,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              SCK,
  input  logic              SS,
  input  logic              MOSI,
  output logic              shift_SPI,
  output logic [7:0]        SPI_in,
  output logic              byte_valid,
  output logic              cost_req,
  output logic              pixel_wen,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [7:0]        pixel_data,
  output logic              image_ready,
  output logic              frame_abort,
  output logic              busy
);

  localparam logic [7:0]        CMD_COST = 8'h01;
  localparam logic [7:0]        CMD_LOAD = 8'h02;
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // synchronizer stages
  logic sck_s1, sck_s2, sck_prev;
  logic ss_s1, ss_s2;
  logic mosi_s1, mosi_s2;

  // byte assembly
  logic [6:0] sr;
  logic [2:0] bit_cnt;
  logic [7:0] rx_byte;
  logic       rx_valid;

  // command / load control
  state_t            state, state_next;
  logic [ADDR_W-1:0] pix_cnt, pix_cnt_next;

  // Two-flop synchronizers plus previous-SCK flop for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sck_s1   <= 1'b0;
      sck_s2   <= 1'b0;
      sck_prev <= 1'b0;
      ss_s1    <= 1'b1;
      ss_s2    <= 1'b1;
      mosi_s1  <= 1'b0;
      mosi_s2  <= 1'b0;
    end else begin
      sck_s1   <= SCK;
      sck_s2   <= sck_s1;
      sck_prev <= sck_s2;
      ss_s1    <= SS;
      ss_s2    <= ss_s1;
      mosi_s1  <= MOSI;
      mosi_s2  <= mosi_s1;
    end
  end

  assign shift_SPI = sck_s2 & ~sck_prev & ~ss_s2;

  // Shift register and bit counter; the completed byte is registered for one cycle.
  // Only the seven oldest bits are kept: the eighth comes straight from mosi_s2.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr       <= '0;
      bit_cnt  <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      if (ss_s2) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if (shift_SPI) begin
        sr      <= {sr[5:0], mosi_s2};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_valid <= 1'b1;
          rx_byte  <= {sr, mosi_s2};
        end
      end
    end
  end

  assign byte_valid = rx_valid;
  assign SPI_in     = rx_byte;

  // FSM state and pixel counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      pix_cnt <= '0;
    end else begin
      state   <= state_next;
      pix_cnt <= pix_cnt_next;
    end
  end

  // Command decode, pixel writes and frame completion/abort
  always_comb begin
    state_next   = state;
    pix_cnt_next = pix_cnt;
    cost_req     = 1'b0;
    pixel_wen    = 1'b0;
    pixel_data   = '0;
    image_ready  = 1'b0;
    frame_abort  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          if (rx_byte == CMD_COST) begin
            cost_req = 1'b1;
          end else if (rx_byte == CMD_LOAD) begin
            state_next   = LOAD;
            pix_cnt_next = '0;
          end
        end
      end
      LOAD: begin
        // A byte completed in the same cycle SS is seen high is still written;
        // if it was the last pixel the frame completes instead of aborting.
        if (rx_valid) begin
          pixel_wen    = 1'b1;
          pixel_data   = rx_byte;
          pix_cnt_next = pix_cnt + 1'b1;
        end
        if (rx_valid && (pix_cnt == LAST_PIX)) begin
          state_next = DONE;
        end else if (ss_s2) begin
          frame_abort  = 1'b1;
          state_next   = IDLE;
          pix_cnt_next = '0;
        end
      end
      DONE: begin
        image_ready = 1'b1;
        state_next  = IDLE;
      end
      default: begin
        state_next   = IDLE;
        pix_cnt_next = '0;
      end
    endcase
  end

  assign pixel_addr = pix_cnt;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_spi_input_controller.sv
// Directed bench for spi_input_controller: expected per-byte outcomes are
// queued when a byte is sent and checked when byte_valid appears.
module tb_spi_input_controller;

  localparam int unsigned NPIX = 784;
  localparam int unsigned AW   = 10;

  logic          clk;
  logic          n_rst;
  logic          SCK, SS, MOSI;
  logic          shift_SPI;
  logic [7:0]    SPI_in;
  logic          byte_valid;
  logic          cost_req;
  logic          pixel_wen;
  logic [AW-1:0] pixel_addr;
  logic [7:0]    pixel_data;
  logic          image_ready;
  logic          frame_abort;
  logic          busy;

  spi_input_controller #(.NUM_PIXELS(NPIX), .ADDR_W(AW)) dut (
    .clk(clk), .n_rst(n_rst), .SCK(SCK), .SS(SS), .MOSI(MOSI),
    .shift_SPI(shift_SPI), .SPI_in(SPI_in), .byte_valid(byte_valid),
    .cost_req(cost_req), .pixel_wen(pixel_wen), .pixel_addr(pixel_addr),
    .pixel_data(pixel_data), .image_ready(image_ready),
    .frame_abort(frame_abort), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    b;
    logic          cost;
    logic          wen;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int shift_cnt = 0, abort_cnt = 0, ready_cnt = 0, wen_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_wen = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    MOSI = b;
    SCK  = 1'b0;
    repeat (4) tick();
    SCK = 1'b1;
    repeat (4) tick();
    SCK = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic cost, input logic wen,
                           input logic [AW-1:0] addr);
    exp_t e;
    e.b = b; e.cost = cost; e.wen = wen; e.addr = addr;
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  // Output monitor: scoreboard pops on byte_valid, strobes must be quiet otherwise
  always @(negedge clk) begin
    if (mon_en) begin
      if (shift_SPI) shift_cnt++;
      if (frame_abort) abort_cnt++;
      if (pixel_wen) wen_cnt++;
      if (image_ready) begin
        ready_cnt++;
        check("ready_after_last_write", {prev_wen, 22'd0, prev_addr}, {1'b1, 22'd0, 10'd783});
      end
      if (byte_valid) begin
        check("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("spi_in", SPI_in, e.b);
          check("cost_req", cost_req, e.cost);
          check("pixel_wen", pixel_wen, e.wen);
          if (e.wen) begin
            check("pixel_addr", pixel_addr, e.addr);
            check("pixel_data", pixel_data, e.b);
          end
        end
      end else begin
        check("quiet_between_bytes", {cost_req, pixel_wen, SPI_in}, 0);
      end
      prev_wen  = pixel_wen;
      prev_addr = pixel_addr;
    end
  end

  initial begin
    int s0;
    SCK = 1'b0; SS = 1'b1; MOSI = 1'b0; n_rst = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("rst_outputs_low",
          {shift_SPI, byte_valid, cost_req, pixel_wen, image_ready, frame_abort, busy}, 0);
    check("rst_spi_in", SPI_in, 8'h00);
    check("rst_pixel_addr", pixel_addr, 0);
    check("rst_pixel_data", pixel_data, 8'h00);
    n_rst = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_spi_in", SPI_in, 8'h00);
    mon_en = 1'b1;

    // Single byte receive
    SS = 1'b0;
    repeat (4) tick();
    s0 = shift_cnt;
    send_byte(8'hA5, 1'b0, 1'b0, '0);
    repeat (4) tick();
    check("a5_shift_pulses", shift_cnt - s0, 8);
    check("a5_consumed", exp_q.size(), 0);

    // Cost command stays in IDLE
    send_byte(8'h01, 1'b1, 1'b0, '0);
    repeat (4) tick();
    check("cost_busy", busy, 0);

    // Full image load
    send_byte(8'h02, 1'b0, 1'b0, '0);
    repeat (2) tick();
    check("load_busy", busy, 1);
    for (int i = 0; i < int'(NPIX); i++) send_byte(8'(i), 1'b0, 1'b1, AW'(i));
    repeat (6) tick();
    check("load_writes", wen_cnt, NPIX);
    check("load_ready_once", ready_cnt, 1);
    check("load_busy_after", busy, 0);
    check("load_consumed", exp_q.size(), 0);

    // Abort after 100 pixels and 3 bits
    send_byte(8'h02, 1'b0, 1'b0, '0);
    for (int i = 0; i < 100; i++) send_byte(8'(i + 7), 1'b0, 1'b1, AW'(i));
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    SS = 1'b1;
    repeat (6) tick();
    check("abort_once", abort_cnt, 1);
    check("abort_writes", wen_cnt, NPIX + 100);
    check("abort_busy", busy, 0);
    SS = 1'b0;
    repeat (4) tick();
    send_byte(8'h01, 1'b1, 1'b0, '0);
    repeat (4) tick();

    // Partial byte discarded
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    SS = 1'b1;
    repeat (6) tick();
    SS = 1'b0;
    repeat (4) tick();
    send_byte(8'h01, 1'b1, 1'b0, '0);
    repeat (6) tick();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_abort_total", abort_cnt, 1);
    check("final_ready_total", ready_cnt, 1);
    check("final_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
